// File: rtl/operand_fetch.sv
// operand_fetch: register-operand fetch stage with a 32-entry busy scoreboard.
// Reads the register file combinationally, stalls on RAW/WAW hazards and
// holds one instruction in a valid/ready output register.
// Optional feature: OPERAND_FETCH_FORWARD_EN lets a busy source take the
// write-back data in the write-back cycle instead of waiting one more cycle.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_rd,
  output logic        out_wen
);

  logic [31:0] r_busy;
  logic        r_out_valid;
  logic [31:0] r_out_op1;
  logic [31:0] r_out_op2;
  logic [4:0]  r_out_rd;
  logic        r_out_wen;

  logic        w_src1_busy;
  logic        w_src2_busy;
  logic        w_fwd1;
  logic        w_fwd2;
  logic        w_hazard;
  logic        w_waw;
  logic        w_accept;
  logic        w_set;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_busy_next;

  // Register-file addresses follow the incoming source fields directly.
  assign rf_raddr1 = in_rs;
  assign rf_raddr2 = in_rt;

  // A source is only busy if it is a real register (r0 is never tracked).
  assign w_src1_busy = (in_rs != 5'd0) & r_busy[in_rs];
  assign w_src2_busy = (in_rt != 5'd0) & r_busy[in_rt];

`ifdef OPERAND_FETCH_FORWARD_EN
  // The register file still shows the old value this cycle, so a busy source
  // being written back right now takes wb_data instead.
  assign w_fwd1 = w_src1_busy & wb_valid & (wb_addr == in_rs);
  assign w_fwd2 = w_src2_busy & wb_valid & (wb_addr == in_rt);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  // WAW: a second writer of a still-pending destination must wait, even if
  // its write-back is happening this very cycle.
  assign w_waw    = in_wen & (in_rd != 5'd0) & r_busy[in_rd];
  assign w_hazard = (w_src1_busy & ~w_fwd1) | (w_src2_busy & ~w_fwd2) | w_waw;

  assign in_ready = ~rst & (~r_out_valid | out_ready) & ~w_hazard;
  assign w_accept = in_valid & in_ready;
  assign w_set    = w_accept & in_wen & (in_rd != 5'd0);

  assign w_op1 = (in_rs == 5'd0) ? 32'h0 : (w_fwd1 ? wb_data : rf_rdata1);
  assign w_op2 = (in_rt == 5'd0) ? 32'h0 : (w_fwd2 ? wb_data : rf_rdata2);

  // Scoreboard next state per register: a new writer's set wins over a clear.
  assign w_busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign w_busy_next[gi] = (w_set & (in_rd == 5'(gi))) |
                               (r_busy[gi] & ~(wb_valid & (wb_addr == 5'(gi))));
    end
  endgenerate

  // Scoreboard and output register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 32'h0;
      r_out_valid <= 1'b0;
      r_out_op1   <= 32'h0;
      r_out_op2   <= 32'h0;
      r_out_rd    <= 5'd0;
      r_out_wen   <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_op1   <= w_op1;
        r_out_op2   <= w_op2;
        r_out_rd    <= in_rd;
        r_out_wen   <= in_wen & (in_rd != 5'd0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_op1   = r_out_op1;
  assign out_op2   = r_out_op2;
  assign out_rd    = r_out_rd;
  assign out_wen   = r_out_wen;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios followed by randomized traffic, all
// compared against a transaction-level model (pending-writer set plus an
// expected-output queue) and a behavioural register file owned by the bench.
`timescale 1ns/1ps
module tb_operand_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic        in_wen = 1'b0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wen;

  // Behavioural register file, written by the bench just after each edge.
  logic [31:0] rf_mem [32];
  logic        force_ones = 1'b0;
  assign rf_rdata1 = force_ones ? 32'hFFFF_FFFF : rf_mem[rf_raddr1];
  assign rf_rdata2 = force_ones ? 32'hFFFF_FFFF : rf_mem[rf_raddr2];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wen(out_wen)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
  } txn_t;

  txn_t exp_q[$];
  bit   pend [32];
  bit   armed = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value an instruction must capture for source r.
  function automatic logic [31:0] model_src(input logic [4:0] r, input bit wbv,
                                            input logic [4:0] wba, input logic [31:0] wbd);
    if (r == 5'd0) return 32'h0;
`ifdef OPERAND_FETCH_FORWARD_EN
    if (pend[r] && wbv && wba == r) return wbd;
`endif
    if (force_ones) return 32'hFFFF_FFFF;
    return rf_mem[r];
  endfunction

  // Whether source r must wait for its pending writer.
  function automatic bit src_stalls(input logic [4:0] r, input bit wbv, input logic [4:0] wba);
    if (r == 5'd0 || !pend[r]) return 1'b0;
`ifdef OPERAND_FETCH_FORWARD_EN
    if (wbv && wba == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational handshake, then advance the model across the edge.
  task automatic step(input bit do_rst, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input bit wen, input bit ordy,
                      input bit wbv, input logic [4:0] wba, input logic [31:0] wbd,
                      output bit acc);
    txn_t t;
    bit   exp_rdy;
    if (armed) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_op1", out_op1, exp_q[0].op1);
        check("out_op2", out_op2, exp_q[0].op2);
        check("out_rd",  out_rd,  exp_q[0].rd);
        check("out_wen", out_wen, exp_q[0].wen);
      end
    end
    rst = do_rst; in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_wen = wen;
    out_ready = ordy; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    #1;
    check("rf_raddr1", rf_raddr1, rs);
    check("rf_raddr2", rf_raddr2, rt);
    exp_rdy = !do_rst && (exp_q.size() == 0 || ordy) &&
              !(src_stalls(rs, wbv, wba) || src_stalls(rt, wbv, wba) ||
                (wen && rd != 5'd0 && pend[rd]));
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    t.op1 = model_src(rs, wbv, wba, wbd);
    t.op2 = model_src(rt, wbv, wba, wbd);
    t.rd  = rd;
    t.wen = wen && rd != 5'd0;
    @(posedge clk);
    #1;
    if (do_rst) begin
      exp_q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ordy) begin
        $display("txn op1=%h op2=%h rd=%0d wen=%0d", exp_q[0].op1, exp_q[0].op2,
                 exp_q[0].rd, exp_q[0].wen);
        void'(exp_q.pop_front());
      end
      if (wbv && wba != 5'd0) pend[wba] = 1'b0;
      if (acc) begin
        if (wen && rd != 5'd0) pend[rd] = 1'b1;
        exp_q.push_back(t);
      end
    end
    if (wbv) rf_mem[wba] = wbd;
    @(negedge clk);
  endtask

  initial begin
    bit          a;
    bit          hold;
    bit          cv, ordy, wbv, rr;
    logic [4:0]  crs, crt, crd, wba;
    logic [31:0] wbd, snap;
    bit          cwen;
    int          n, idx;

    foreach (rf_mem[i]) rf_mem[i] = $urandom;
    foreach (pend[i]) pend[i] = 1'b0;
    @(negedge clk);

    // Reset with a valid instruction present: nothing accepted, outputs cleared.
    step(1, 1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 32'h0, a);
    armed = 1'b1;
    check("rst_acc",   a, 0);
    check("rst_valid", out_valid, 0);
    check("rst_op1",   out_op1, 0);
    check("rst_op2",   out_op2, 0);
    check("rst_rd",    out_rd, 0);
    check("rst_wen",   out_wen, 0);

    // Basic capture with one-cycle latency.
    rf_mem[1] = 32'h11; rf_mem[2] = 32'h22;
    step(0, 1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 32'h0, a);
    check("basic_acc",   a, 1);
    check("basic_valid", out_valid, 1);
    check("basic_op1",   out_op1, 32'h11);
    check("basic_op2",   out_op2, 32'h22);
    check("basic_rd",    out_rd, 5'd3);
    check("basic_wen",   out_wen, 1);

    // RAW on r3 resolved by a write-back two cycles later.
    step(0, 1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0, a);
    check("raw_stall0", a, 0);
    step(0, 1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0, a);
    check("raw_stall1", a, 0);
    step(0, 1, 5'd3, 5'd0, 5'd0, 0, 1, 1, 5'd3, 32'hABCD, a);
`ifdef OPERAND_FETCH_FORWARD_EN
    check("raw_fwd_acc", a, 1);
`else
    check("raw_wb_stall", a, 0);
    step(0, 1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0, a);
    check("raw_acc", a, 1);
`endif
    check("raw_op1", out_op1, 32'hABCD);

    // r0 sources read as zero; rd=0 never writes.
    force_ones = 1'b1;
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0, a);
    force_ones = 1'b0;
    check("r0_acc", a, 1);
    check("r0_op1", out_op1, 0);
    check("r0_op2", out_op2, 0);
    check("r0_wen", out_wen, 0);

    // Backpressure: three cycles blocked, outputs frozen, then one per cycle.
    snap = out_op1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'd1, 5'd2, 5'd4, 1, 0, 0, 5'd0, 32'h0, a);
      check("bp_blocked", a, 0);
      check("bp_stable",  out_op1, snap);
    end
    step(0, 1, 5'd1, 5'd2, 5'd4, 1, 1, 0, 5'd0, 32'h0, a);
    check("bp_acc0", a, 1);
    step(0, 1, 5'd2, 5'd1, 5'd6, 1, 1, 0, 5'd0, 32'h0, a);
    check("bp_acc1", a, 1);
    step(0, 1, 5'd1, 5'd1, 5'd8, 1, 1, 0, 5'd0, 32'h0, a);
    check("bp_acc2", a, 1);

    // Set and clear of r5 in one cycle: set wins, next writer of r5 stalls.
    step(0, 1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 5'd5, 32'h55, a);
    check("setclr_acc", a, 1);
    step(0, 1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 5'd0, 32'h0, a);
    check("waw_stall", a, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd5, 32'h56, a);

    // Reset mid-flight with r7 pending and the output full.
    step(0, 1, 5'd1, 5'd2, 5'd7, 1, 0, 0, 5'd0, 32'h0, a);
    check("r7_acc", a, 1);
    step(1, 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 5'd0, 32'h0, a);
    check("midrst_acc",   a, 0);
    check("midrst_valid", out_valid, 0);
    step(0, 1, 5'd7, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0, a);
    check("post_rst_acc", a, 1);

    // Randomized traffic; each instruction is offered until it is accepted.
    hold = 1'b0;
    crs = 5'd0; crt = 5'd0; crd = 5'd0; cwen = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!hold) begin
        crs  = 5'($urandom_range(0, 7));
        crt  = 5'($urandom_range(0, 7));
        crd  = 5'($urandom_range(0, 7));
        cwen = 1'($urandom_range(0, 1));
      end
      cv   = $urandom_range(0, 9) < 8;
      ordy = $urandom_range(0, 9) < 7;
      wbv  = 1'b0;
      wba  = 5'd0;
      wbd  = $urandom;
      if ($urandom_range(0, 9) < 4) begin
        n = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          idx = (n + k) % 32;
          if (!wbv && pend[idx]) begin
            wbv = 1'b1;
            wba = 5'(idx);
          end
        end
        if (!wbv && $urandom_range(0, 3) == 0) begin
          wbv = 1'b1;
          wba = 5'($urandom_range(0, 7));
        end
      end
      rr = (c % 250) == 249;
      step(rr, cv, crs, crt, crd, cwen, ordy, wbv, wba, wbd, a);
      hold = !a;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
